// File: rtl/wb_pkg.sv
// Shared types for the write-back/commit stage.
// Load-size encodings and the default-width queue entry layout.
// No logic; imported by the extender and the commit unit.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 4;

    // ld_size encodings; any value with bit 1 set is treated as a word load
    typedef enum logic [1:0] {
        LD_BYTE = 2'b00,
        LD_HALF = 2'b01,
        LD_WORD = 2'b10
    } ld_size_e;

    // One completed instruction waiting to retire (default datapath widths)
    typedef struct packed {
        logic [WB_DATA_W-1:0] pc;
        logic [WB_DATA_W-1:0] value;
        logic [WB_ADDR_W-1:0] dest;
        logic                 wb_en;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_ext.sv
// Sub-word load extender: picks byte/half/word from the loaded data and extends it.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select by address offset, then zero/sign extend; half loads ignore offset[0]
    always_comb begin
        byte_sel = data[{offset, 3'b000} +: 8];
        half_sel = data[{offset[1], 4'b0000} +: 16];
        value    = data;
        if (size == LD_BYTE) begin
            value = {{(DATA_W-8){is_signed & byte_sel[7]}}, byte_sel};
        end else if (size == LD_HALF) begin
            value = {{(DATA_W-16){is_signed & half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: selects the write value, queues DEPTH instructions, retires in order.
// Latency: push at edge N is presented at the head during cycle N+1 (empty queue).
// Backpressure: in_ready drops only when full; rf_ready stalls only wb_en head entries.
// Optional sub-word load extension is built when WB_LOAD_EXT_EN is defined.
module wb_commit_unit
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic                     wb_en,
    input  logic                     mem_r_en,
    input  logic [1:0]               ld_size,
    input  logic                     ld_signed,
    input  logic [1:0]               byte_off,
    input  logic [DATA_W-1:0]        alu_res,
    input  logic [DATA_W-1:0]        data_mem,
    input  logic [ADDR_W-1:0]        dest,
    input  logic                     flush,
    input  logic                     rf_ready,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_dest,
    output logic [DATA_W-1:0]        rf_value,
    output logic [DATA_W-1:0]        pc_out,
    input  logic [ADDR_W-1:0]        hz_src0,
    input  logic [ADDR_W-1:0]        hz_src1,
    output logic                     hz_hit0,
    output logic                     hz_hit1,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         retire_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [ADDR_W-1:0] dest_q  [DEPTH];
    logic [DEPTH-1:0]  wb_en_q;
    logic [DEPTH-1:0]  vld_q;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  count;

    logic [DATA_W-1:0] ext_val;
    logic [DATA_W-1:0] push_val;
    logic              push_fire;
    logic              pop_fire;
    logic              head_vld;

`ifdef WB_LOAD_EXT_EN
    wb_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .data      (data_mem),
        .size      (ld_size),
        .is_signed (ld_signed),
        .offset    (byte_off),
        .value     (ext_val)
    );
`else
    // Without extension the loaded word passes through; size/sign/offset are don't-care
    logic unused_ld_cfg;
    assign unused_ld_cfg = ^{ld_size, ld_signed, byte_off};
    assign ext_val       = data_mem;
`endif

    assign push_val  = mem_r_en ? ext_val : alu_res;
    assign in_ready  = (count < OCC_W'(DEPTH));
    assign push_fire = in_valid && in_ready;
    assign head_vld  = vld_q[rd_ptr];
    assign pop_fire  = head_vld && (!wb_en_q[rd_ptr] || rf_ready);
    assign occupancy = count;

    // Head fields are forced to zero when the queue is empty
    always_comb begin
        rf_we    = head_vld && wb_en_q[rd_ptr];
        rf_dest  = '0;
        rf_value = '0;
        pc_out   = '0;
        if (head_vld) begin
            rf_dest  = dest_q[rd_ptr];
            rf_value = value_q[rd_ptr];
            pc_out   = pc_q[rd_ptr];
        end
    end

    // Pending-write hazard scan over queued entries only (not the incoming one)
    always_comb begin
        hz_hit0 = 1'b0;
        hz_hit1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && wb_en_q[i] && (dest_q[i] == hz_src0)) hz_hit0 = 1'b1;
            if (vld_q[i] && wb_en_q[i] && (dest_q[i] == hz_src1)) hz_hit1 = 1'b1;
        end
    end

    // Entry payload storage; validity is tracked separately so no reset is needed here
    always_ff @(posedge clk) begin
        if (push_fire && !flush) begin
            pc_q[wr_ptr]    <= pc_in;
            value_q[wr_ptr] <= push_val;
            dest_q[wr_ptr]  <= dest;
        end
    end

    // Queue control: pointers, valid bits, occupancy; flush wins over push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= '0;
            wb_en_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else if (flush) begin
            vld_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                vld_q[wr_ptr]   <= 1'b1;
                wb_en_q[wr_ptr] <= wb_en;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push_fire && !pop_fire) begin
                count <= count + OCC_W'(1);
            end else if (!push_fire && pop_fire) begin
                count <= count - OCC_W'(1);
            end
        end
    end

    // Retire counter: a pop coinciding with flush still writes but is not counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (pop_fire && !flush) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are sampled before the next edge.
// Load-extension expectations follow WB_LOAD_EXT_EN.
module tb_wb_commit_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 32;

`ifdef WB_LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pc_in;
    logic              wb_en;
    logic              mem_r_en;
    logic [1:0]        ld_size;
    logic              ld_signed;
    logic [1:0]        byte_off;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] data_mem;
    logic [ADDR_W-1:0] dest;
    logic              flush;
    logic              rf_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_dest;
    logic [DATA_W-1:0] rf_value;
    logic [DATA_W-1:0] pc_out;
    logic [ADDR_W-1:0] hz_src0;
    logic [ADDR_W-1:0] hz_src1;
    logic              hz_hit0;
    logic              hz_hit1;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0]  retire_cnt;

    int checks  = 0;
    int errors  = 0;
    int exp_ret = 0;

    // Load extension table: size, signed, offset, expected value with extension enabled
    logic [1:0]  ld_sz_t  [7] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11};
    logic        ld_sg_t  [7] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic [1:0]  ld_of_t  [7] = '{2'd2,  2'd2,  2'd0,  2'd0,  2'd3,  2'd1,  2'd1};
    logic [31:0] ld_exp_t [7] = '{32'hFFFF_FFF0, 32'h0000_80F0, 32'h80F0_7F81, 32'h0000_0081,
                                  32'hFFFF_80F0, 32'h0000_007F, 32'h80F0_7F81};

    wb_commit_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc_in      (pc_in),
        .wb_en      (wb_en),
        .mem_r_en   (mem_r_en),
        .ld_size    (ld_size),
        .ld_signed  (ld_signed),
        .byte_off   (byte_off),
        .alu_res    (alu_res),
        .data_mem   (data_mem),
        .dest       (dest),
        .flush      (flush),
        .rf_ready   (rf_ready),
        .rf_we      (rf_we),
        .rf_dest    (rf_dest),
        .rf_value   (rf_value),
        .pc_out     (pc_out),
        .hz_src0    (hz_src0),
        .hz_src1    (hz_src1),
        .hz_hit0    (hz_hit0),
        .hz_hit1    (hz_hit1),
        .occupancy  (occupancy),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dm,
                         input logic [3:0] d, input logic we, input logic mr,
                         input logic [1:0] sz, input logic sg, input logic [1:0] off);
        in_valid  = 1'b1;
        pc_in     = pc;
        alu_res   = alu;
        data_mem  = dm;
        dest      = d;
        wb_en     = we;
        mem_r_en  = mr;
        ld_size   = sz;
        ld_signed = sg;
        byte_off  = off;
    endtask

    // Directed sequence
    initial begin
        rst = 1'b0;
        in_valid = 1'b0; pc_in = '0; wb_en = 1'b0; mem_r_en = 1'b0;
        ld_size = 2'b00; ld_signed = 1'b0; byte_off = 2'b00;
        alu_res = '0; data_mem = '0; dest = '0; flush = 1'b0; rf_ready = 1'b0;
        hz_src0 = '0; hz_src1 = '0;

        // Reset state
        #3;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_value", rf_value, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hz0", 32'(hz_hit0), 32'd0);
        #9 rst = 1'b1;
        tick();

        // Basic push and retire with one-cycle latency
        rf_ready = 1'b1;
        hz_src0  = 4'd3;
        drive(32'h100, 32'h1234, 32'h0, 4'd3, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
        chk("b_in_ready", 32'(in_ready), 32'd1);
        chk("b_hz_incoming", 32'(hz_hit0), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("b_rf_we", 32'(rf_we), 32'd1);
        chk("b_rf_dest", 32'(rf_dest), 32'd3);
        chk("b_rf_value", rf_value, 32'h1234);
        chk("b_pc_out", pc_out, 32'h100);
        chk("b_occ", 32'(occupancy), 32'd1);
        chk("b_retire0", retire_cnt, 32'd0);
        chk("b_hz_queued", 32'(hz_hit0), 32'd1);
        tick();
        exp_ret++;
        chk("b_retire1", retire_cnt, 32'(exp_ret));
        chk("b_occ_empty", 32'(occupancy), 32'd0);
        chk("b_rf_we_empty", 32'(rf_we), 32'd0);

        // Load value selection/extension
        for (int i = 0; i < 7; i++) begin
            drive(32'h300 + 32'(i), 32'hDEAD_0000 + 32'(i), 32'h80F0_7F81, 4'd5, 1'b1, 1'b1,
                  ld_sz_t[i], ld_sg_t[i], ld_of_t[i]);
            tick();
            in_valid = 1'b0;
            chk("load_ext", rf_value, EXT ? ld_exp_t[i] : 32'h80F0_7F81);
            tick();
            exp_ret++;
        end
        drive(32'h380, 32'hCAFE_F00D, 32'h80F0_7F81, 4'd5, 1'b1, 1'b0, 2'b00, 1'b1, 2'd2);
        tick();
        in_valid = 1'b0;
        chk("alu_select", rf_value, 32'hCAFE_F00D);
        tick();
        exp_ret++;
        chk("load_retire", retire_cnt, 32'(exp_ret));

        // Fill to full with the register file stalled
        rf_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(32'h200 + 32'(4*i), 32'hA0 + 32'(i), 32'h0, 4'(i + 1), 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
            chk("fill_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_rf_we", 32'(rf_we), 32'd1);
        tick();
        chk("stall_occ", 32'(occupancy), 32'd4);
        chk("stall_retire", retire_cnt, 32'(exp_ret));
        rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_value", rf_value, 32'hA0 + 32'(i));
            chk("drain_dest", 32'(rf_dest), 32'(i + 1));
            chk("drain_pc", pc_out, 32'h200 + 32'(4*i));
            chk("drain_occ", 32'(occupancy), 32'(4 - i));
            tick();
            exp_ret++;
        end
        chk("drain_empty", 32'(occupancy), 32'd0);
        chk("drain_no_fifth", 32'(rf_we), 32'd0);
        chk("drain_retire", retire_cnt, 32'(exp_ret));

        // Hazard detection and wb_en=0 retirement without rf_ready
        rf_ready = 1'b0;
        hz_src0  = 4'd7;
        hz_src1  = 4'd2;
        drive(32'h500, 32'h77, 32'h0, 4'd7, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
        tick();
        drive(32'h504, 32'h22, 32'h0, 4'd2, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0);
        chk("hz0_hit", 32'(hz_hit0), 32'd1);
        chk("hz1_incoming", 32'(hz_hit1), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("hz0_hit_q", 32'(hz_hit0), 32'd1);
        chk("hz1_no_wb", 32'(hz_hit1), 32'd0);
        chk("hz_occ", 32'(occupancy), 32'd2);
        rf_ready = 1'b1;
        tick();
        exp_ret++;
        rf_ready = 1'b0;
        chk("nowb_rf_we", 32'(rf_we), 32'd0);
        chk("nowb_dest", 32'(rf_dest), 32'd2);
        chk("nowb_hz0_gone", 32'(hz_hit0), 32'd0);
        chk("nowb_occ", 32'(occupancy), 32'd1);
        tick();
        exp_ret++;
        chk("nowb_popped", 32'(occupancy), 32'd0);
        chk("nowb_retire", retire_cnt, 32'(exp_ret));

        // Flush with a same-cycle push and pop
        for (int i = 0; i < 3; i++) begin
            drive(32'h600 + 32'(4*i), 32'hF0 + 32'(i), 32'h0, 4'(9 + i), 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
            tick();
        end
        drive(32'h60C, 32'hBAD, 32'h0, 4'd12, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
        chk("pre_flush_occ", 32'(occupancy), 32'd3);
        flush    = 1'b1;
        rf_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        rf_ready = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_rf_we", 32'(rf_we), 32'd0);
        chk("flush_retire", retire_cnt, 32'(exp_ret));
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("flush_no_push", 32'(occupancy), 32'd0);
        chk("flush_value", rf_value, 32'd0);

        // Simultaneous push and pop keeps occupancy constant
        rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(32'h700 + 32'(4*i), 32'hC0 + 32'(i), 32'h0, 4'd6, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
            tick();
            if (i > 0) exp_ret++;
            chk("thru_occ", 32'(occupancy), 32'd1);
            chk("thru_value", rf_value, 32'hC0 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        exp_ret++;
        chk("thru_empty", 32'(occupancy), 32'd0);
        chk("thru_retire", retire_cnt, 32'(exp_ret));

        // Asynchronous reset in the middle of operation
        rf_ready = 1'b0;
        hz_src0  = 4'd8;
        drive(32'h400, 32'h55, 32'h0, 4'd8, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("pre_arst_hz0", 32'(hz_hit0), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_rf_we", 32'(rf_we), 32'd0);
        chk("arst_dest", 32'(rf_dest), 32'd0);
        chk("arst_value", rf_value, 32'd0);
        chk("arst_pc", pc_out, 32'd0);
        chk("arst_retire", retire_cnt, 32'd0);
        chk("arst_hz0", 32'(hz_hit0), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b1;
        tick();
        chk("post_arst_occ", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Parametrised write-back/commit stage for the ARM pipeline, sitting between the MEM stage and the register file. Selects the write-back value (ALU result or memory data with optional sub-word load extension), buffers completed instructions in a DEPTH-entry in-order queue so a stalled register-file port does not stall MEM, and retires them in order. Also exposes pending-write hazard checks and a retired-instruction counter.

## Interface
- DATA_W, 32, datapath and PC width
- ADDR_W, 4, register index width
- DEPTH, 4, queue entries; power of two, ≥2
- CNT_W, 32, retire counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  unit accepts the instruction this cycle
- pc_in  in  DATA_W  instruction PC
- wb_en, mem_r_en  in  1 each  register write enable; value comes from memory
- ld_size  in  2  00 byte, 01 half, 1x word
- ld_signed  in  1  sign-extend sub-word loads
- byte_off  in  2  address bits [1:0] of the load
- alu_res, data_mem  in  DATA_W each  candidate write values
- dest  in  ADDR_W  destination register
- flush  in  1  discard all queued instructions
- rf_ready  in  1  register-file port accepts a write
- rf_we  out  1  head entry writes the register file
- rf_dest  out  ADDR_W, rf_value  out  DATA_W, pc_out  out  DATA_W  head entry fields
- hz_src0, hz_src1  in  ADDR_W  source registers to check
- hz_hit0, hz_hit1  out  1  a queued entry with wb_en writes that register
- occupancy  out  $clog2(DEPTH)+1  valid entries
- retire_cnt  out  CNT_W  instructions retired since reset

## Operation
- Push: in_valid && in_ready. in_ready = (occupancy < DEPTH); no combinational path from rf_ready or in_valid.
- Value is computed at push and stored: mem_r_en ? ext(data_mem) : alu_res.
- ext: byte = data_mem[8*byte_off +: 8]; half = data_mem[16*byte_off[1] +: 16] (byte_off[0] ignored); word = data_mem. Zero-extend, or sign-extend when ld_signed.
- Every accepted instruction is queued, including wb_en=0 ones.
- Head outputs: rf_we = head valid && head wb_en; rf_dest/rf_value/pc_out = head fields, all zero when empty.
- Pop: head valid && (!head wb_en || rf_ready). wb_en=0 entries retire without waiting on rf_ready.
- retire_cnt increments by 1 per pop, wraps modulo 2^CNT_W, never cleared by flush.
- Hazard: hz_hitN = OR over valid entries of (wb_en && dest == hz_srcN); combinational; does not include the instruction being pushed this cycle.
- Push and pop in the same cycle: occupancy unchanged. Full: in_ready=0, pop still allowed.
- flush (synchronous): all entries invalidated, occupancy→0 at next edge; a same-cycle push is dropped; a same-cycle pop still performs its register write (already committed) but does not increment retire_cnt.

## Timing
- Reset (rst low, asynchronous): occupancy 0, rf_we 0, rf_dest 0, rf_value 0, pc_out 0, retire_cnt 0, hz_hit* 0; in_ready 1 once occupancy is 0.
- Latency: push at edge N into empty queue → rf_we/rf_value valid during cycle N+1; written at edge N+1 if rf_ready.
- Throughput: one push and one pop per cycle.
- Reset mid-operation discards all entries immediately; no partial writes after rst falls.

## Configuration
- WB_LOAD_EXT_EN defined: ld_size/ld_signed/byte_off extension as above.
- Undefined: ext(data_mem) = data_mem unchanged; ld_size, ld_signed, byte_off ports remain but are ignored.

## Structure
- Package wb_pkg: ld_size encodings (LD_BYTE, LD_HALF, LD_WORD), wb_entry_t struct {pc, value, dest, wb_en}.
- Sub-module wb_load_ext: combinational extender (data, size, signed, offset → value), instantiated only under WB_LOAD_EXT_EN.

## Test plan
- Reset then push alu_res=0x1234, dest=3, wb_en=1, rf_ready=1 → next cycle rf_we=1, rf_dest=3, rf_value=0x1234; retire_cnt 0→1.
- Load data_mem=0x80F0_7F81, byte_off=2, byte signed → 0xFFFF_FFF0; half unsigned byte_off=2 → 0x0000_80F0; word → 0x80F0_7F81; with macro undefined all → 0x80F0_7F81.
- rf_ready=0, push 5 instructions DEPTH=4 → in_ready=0 after 4th, occupancy=4; raise rf_ready → in-order retire, one per cycle.
- Queue holds dest=7 wb_en=1 and dest=2 wb_en=0; hz_src0=7 → hz_hit0=1; hz_src1=2 → hz_hit1=0.
- Head wb_en=0 with rf_ready=0 → pops immediately, rf_we=0, retire_cnt increments.
- Occupancy 3, assert flush with in_valid=1 → occupancy 0 next cycle, pushed instruction absent; rst low mid-stream → all outputs zero asynchronously.
